fir_out_fifo: RTL and testbench

FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

---
 rtl/fir_out_fifo.sv | 105 ++++++++++
 tb/tb_fir_out_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: output FIFO for the FIR stream. It buffers {tlast, tdata} beats
// between the filter's sm port and a downstream AXI-Stream sink. It also counts
// completed frames and the beats of the frame in progress.
module fir_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pLVL_WIDTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   flush,
  output logic [pLVL_WIDTH-1:0]  level,
  output logic [31:0]            frame_cnt,
  output logic [31:0]            beat_cnt
);

  localparam int PTR_W = $clog2(pDEPTH);
  localparam logic [pLVL_WIDTH-1:0] LVL_FULL = pLVL_WIDTH'(pDEPTH);

  // Entry layout: MSB is tlast, the rest is tdata. Never reset; the level
  // counter guards against reading an unwritten entry.
  logic [pDATA_WIDTH:0]  mem_q [pDEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [pLVL_WIDTH-1:0] level_q,  level_d;
  logic [31:0]           frame_q,  frame_d;
  logic [31:0]           beat_q,   beat_d;

  logic push, pop;

  // Handshake outputs depend only on registered state (plus flush), so
  // ss_tready never combinationally follows sm_tready.
  assign ss_tready = (level_q != LVL_FULL) && !flush;
  assign sm_tvalid = (level_q != '0);
  assign sm_tdata  = mem_q[rd_ptr_q][pDATA_WIDTH-1:0];
  assign sm_tlast  = mem_q[rd_ptr_q][pDATA_WIDTH];

  assign push = ss_tvalid && ss_tready;
  assign pop  = sm_tvalid && sm_tready && !flush;

  assign level     = level_q;
  assign frame_cnt = frame_q;
  assign beat_cnt  = beat_q;

  // Next-state for pointers, occupancy and frame/beat counters; flush overrides all.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    frame_d  = frame_q;
    beat_d   = beat_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      frame_d  = '0;
      beat_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (sm_tlast) begin
          frame_d = frame_q + 32'd1;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 32'd1;
        end
      end
      if (push && !pop)      level_d = level_q + pLVL_WIDTH'(1);
      else if (pop && !push) level_d = level_q - pLVL_WIDTH'(1);
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frame_q  <= '0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frame_q  <= frame_d;
      beat_q   <= beat_d;
    end
  end

  // Storage write on an accepted beat.
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {ss_tlast, ss_tdata};
  end

endmodule

// File: tb/tb_fir_out_fifo.sv
// tb_fir_out_fifo: directed bench for fir_out_fifo with immediate-assertion checks.
module tb_fir_out_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic [31:0] sm_tdata;
  logic        flush;
  logic [3:0]  level;
  logic [31:0] frame_cnt, beat_cnt;

  int checks = 0;
  int failures = 0;

  fir_out_fifo #(.pDATA_WIDTH(32), .pDEPTH(8), .pLVL_WIDTH(4)) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .sm_tready (sm_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .flush     (flush),
    .level     (level),
    .frame_cnt (frame_cnt),
    .beat_cnt  (beat_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  int next_in, exp_out, mlvl, cyc;
  logic pu, po;

  initial begin
    axis_rst_n = 1'b0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    sm_tready = 1'b0; flush = 1'b0;
    #13;
    // Reset values
    chk("rst_sm_tvalid", sm_tvalid, 0);
    chk("rst_ss_tready", ss_tready, 1);
    chk("rst_level", level, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_beat", beat_cnt, 0);
    axis_rst_n = 1'b1;
    tick();

    // Single-frame pass-through 3,7,11
    sm_tready = 1'b1;
    ss_tvalid = 1'b1; ss_tdata = 3; ss_tlast = 1'b0;
    tick();
    chk("pt_valid1", sm_tvalid, 1);
    chk("pt_data3", sm_tdata, 3);
    chk("pt_last3", sm_tlast, 0);
    chk("pt_level1", level, 1);
    ss_tdata = 7;
    tick();
    chk("pt_valid_keep", sm_tvalid, 1);
    chk("pt_data7", sm_tdata, 7);
    chk("pt_level_same", level, 1);
    chk("pt_beat1", beat_cnt, 1);
    ss_tdata = 11; ss_tlast = 1'b1;
    tick();
    chk("pt_data11", sm_tdata, 11);
    chk("pt_last11", sm_tlast, 1);
    chk("pt_beat2", beat_cnt, 2);
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    tick();
    chk("pt_frame1", frame_cnt, 1);
    chk("pt_beat0", beat_cnt, 0);
    chk("pt_level0", level, 0);
    chk("pt_valid0", sm_tvalid, 0);

    // Fill to full with the sink stalled
    sm_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ss_tvalid = 1'b1; ss_tdata = 100 + i;
      tick();
    end
    chk("full_level8", level, 8);
    chk("full_ss_tready", ss_tready, 0);
    chk("full_head", sm_tdata, 100);
    ss_tdata = 200;
    tick();
    chk("full_hold_level", level, 8);
    chk("full_hold_head", sm_tdata, 100);

    // Full with simultaneous pop: no push that cycle
    sm_tready = 1'b1;
    tick();
    chk("fp_level7", level, 7);
    chk("fp_ss_tready", ss_tready, 1);
    chk("fp_head101", sm_tdata, 101);
    sm_tready = 1'b0;
    tick();
    chk("fp_level8", level, 8);
    chk("fp_beat1", beat_cnt, 1);
    ss_tvalid = 1'b0;
    sm_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_data", sm_tdata, (i < 7) ? 101 + i : 200);
      tick();
    end
    chk("drain_level0", level, 0);
    chk("drain_beat9", beat_cnt, 9);
    chk("drain_frame1", frame_cnt, 1);

    // Flush clears counters and blocks ss_tready combinationally
    flush = 1'b1;
    #1;
    chk("flush_ss_tready", ss_tready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_frame0", frame_cnt, 0);
    chk("flush_beat0", beat_cnt, 0);
    chk("flush_ready_back", ss_tready, 1);

    // Pointer wrap: 20 beats with random sink ready
    next_in = 0; exp_out = 0; mlvl = 0; cyc = 0;
    while (exp_out < 20 && cyc < 1000) begin
      ss_tvalid = (next_in < 20);
      ss_tdata  = next_in;
      sm_tready = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_level", level, mlvl);
      chk("wrap_ss_tready", ss_tready, (mlvl != 8));
      pu = ss_tvalid && (mlvl != 8);
      po = sm_tready && (mlvl != 0);
      if (po) begin
        chk("wrap_data", sm_tdata, exp_out);
        exp_out++;
      end
      tick();
      if (pu) next_in++;
      mlvl = mlvl + (pu ? 1 : 0) - (po ? 1 : 0);
      cyc++;
    end
    chk("wrap_all_out", exp_out, 20);
    ss_tvalid = 1'b0;
    #1;
    chk("wrap_level0", level, 0);
    chk("wrap_beat20", beat_cnt, 20);

    // Flush mid-frame
    flush = 1'b1; tick(); flush = 1'b0;
    sm_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ss_tvalid = 1'b1; ss_tdata = i;
      tick();
    end
    ss_tvalid = 1'b0; sm_tready = 1'b1;
    tick(); tick();
    sm_tready = 1'b0;
    chk("mf_beat2", beat_cnt, 2);
    chk("mf_level2", level, 2);
    chk("mf_head3", sm_tdata, 3);
    flush = 1'b1; ss_tvalid = 1'b1; ss_tdata = 77; sm_tready = 1'b1;
    #1;
    chk("mf_ss_tready0", ss_tready, 0);
    tick();
    flush = 1'b0; ss_tvalid = 1'b0; sm_tready = 1'b0;
    #1;
    chk("mf_level0", level, 0);
    chk("mf_beat0", beat_cnt, 0);
    chk("mf_frame0", frame_cnt, 0);
    chk("mf_valid0", sm_tvalid, 0);

    // Asynchronous reset at level 5
    for (int i = 0; i < 5; i++) begin
      ss_tvalid = 1'b1; ss_tdata = 30 + i;
      tick();
    end
    ss_tvalid = 1'b0;
    chk("ar_level5", level, 5);
    axis_rst_n = 1'b0;
    #1;
    chk("ar_level0", level, 0);
    chk("ar_valid0", sm_tvalid, 0);
    chk("ar_ss_tready1", ss_tready, 1);
    tick();
    axis_rst_n = 1'b1;
    ss_tvalid = 1'b1; ss_tdata = 55; ss_tlast = 1'b1;
    tick();
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    chk("ar_valid1", sm_tvalid, 1);
    chk("ar_data55", sm_tdata, 55);
    chk("ar_last1", sm_tlast, 1);
    chk("ar_level1", level, 1);
    sm_tready = 1'b1;
    tick();
    chk("ar_frame1", frame_cnt, 1);
    chk("ar_level_end", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
